uart_tx_arbiter: RTL and testbench

- Two-requester UART transmit controller driven by the 16x-oversampled baud enable from the baud-rate generator (100 MHz / (19200*16), one tick every 326 clocks).
- Arbitrates round-robin between two byte sources, e.g. the debug unit and the MIPS program-output path, and serializes the winner's byte as an 8N1 frame on the shared TX line.
- Sits between the requesters and the board UART pin.

---
 rtl/uart_tx_arbiter_if.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the baud tick, the two requester handshakes and the serial-side
//   status outputs of uart_tx_arbiter.
//   slave  : the transmitter side (consumes tick/req/din, drives ack/tx/status)
//   master : the requester/board side (drives tick/req/din, observes the rest)
// Signals:
//   tick          16x baud enable pulse
//   req0/din0     requester 0 byte pending / byte value
//   ack0          one-clock capture pulse for requester 0
//   req1/din1     requester 1 byte pending / byte value
//   ack1          one-clock capture pulse for requester 1
//   tx            serial line, idles high
//   busy          transmitter not idle
//   tx_done       one-clock pulse at end of the last stop bit
//   owner         requester currently (or last) being sent
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int DATA_BITS = 8
);
  logic                 tick;
  logic                 req0;
  logic [DATA_BITS-1:0] din0;
  logic                 ack0;
  logic                 req1;
  logic [DATA_BITS-1:0] din1;
  logic                 ack1;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;
  logic                 owner;

  modport slave (
    input  tick, req0, din0, req1, din1,
    output ack0, ack1, tx, busy, tx_done, owner
  );

  modport master (
    output tick, req0, din0, req1, din1,
    input  ack0, ack1, tx, busy, tx_done, owner
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Two-requester UART transmitter. Picks one pending byte round-robin,
//   captures it, and sends it LSB first as a start/data/stop frame timed by a
//   16x oversampled baud tick.
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      uart_tx_arbiter_if.slave: tick, req0/din0/ack0, req1/din1/ack1,
//            tx, busy, tx_done, owner
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
  localparam int STOP_W = (STOP_BITS  > 1) ? $clog2(STOP_BITS)  : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state_q,    state_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                 prio_q,     prio_d;   // 1: requester 1 wins a tie
  logic                 owner_q,    owner_d;
  logic                 ack0_q,     ack0_d;
  logic                 ack1_q,     ack1_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic bit_end;
  logic gnt1;

  // NOTE: every combinational output gets a default at the top of the block;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done_d     = 1'b0;
    // busy follows the state one clock late, so it rises the edge after grant.
    busy_d     = (state_q != IDLE);
    gnt1       = 1'b0;

    // The counted tick that closes a bit period; ticks in IDLE never count,
    // which also keeps a tick on the grant edge out of the START period.
    bit_end = (state_q != IDLE) && bus.tick && (tick_cnt_q == TICK_LAST);

    if ((state_q != IDLE) && bus.tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Lone request wins outright; on a tie the pointer decides.
          gnt1       = bus.req1 && (!bus.req0 || prio_q);
          shreg_d    = gnt1 ? bus.din1 : bus.din0;
          ack0_d     = !gnt1;
          ack1_d     = gnt1;
          owner_d    = gnt1;
          prio_d     = !gnt1;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            stop_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is computed from the next state and registered, so the
    // pin changes on the same edge as the state and never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      prio_q     <= 1'b0;
      owner_q    <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      prio_q     <= prio_d;
      owner_q    <= owner_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter. Expected frames (owner + byte) are
//   queued when requests are raised; a line monitor decodes tx against the
//   head of the queue, checking every bit level over its full 16-tick period,
//   the tx_done pulse and the owner.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.DATA_BITS(8)) bus ();

  uart_tx_arbiter #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .STOP_BITS (1)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  int   done_cnt    = 0;
  int   done_cycle  = 0;
  int   ack_cnt0    = 0;
  int   ack_cnt1    = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cycle++;

  // Tick source: every 4th clock, or every clock when tick_stuck is set.
  bit tick_stuck = 1'b0;
  int div        = 0;
  always begin
    @(posedge clock);
    #1;
    div      = (div + 1) % 4;
    bus.tick = tick_stuck || (div == 0);
  end

  // Line monitor / scoreboard consumer, sampling on the falling edge.
  logic       active = 1'b0;
  int         n      = 0;
  logic       bit_ok = 1'b1;
  logic [9:0] pattern;
  exp_t       cur;

  always @(negedge clock) begin
    if (!reset_n) begin
      active = 1'b0;
      n      = 0;
    end else begin
      if (bus.ack0 === 1'b1) ack_cnt0++;
      if (bus.ack1 === 1'b1) ack_cnt1++;
      if (bus.tx_done === 1'b1) begin
        done_cnt++;
        done_cycle = cycle;
      end
      if (!active && bus.tx === 1'b0) begin
        check("frame_expected", 32'(sb_q.size() != 0), 1);
        cur     = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        pattern = {1'b1, cur.data, 1'b0};
        active  = 1'b1;
        n       = 0;
        bit_ok  = 1'b1;
        check("owner_at_start", bus.owner, cur.owner);
      end
      if (active) begin
        if (n == 160) begin
          check("tx_done_at_frame_end", bus.tx_done, 1);
          check("owner_at_end", bus.owner, cur.owner);
          active = 1'b0;
        end else begin
          if (bus.tx !== pattern[n/16] || bus.tx_done !== 1'b0) bit_ok = 1'b0;
          if (bus.tick === 1'b1) begin
            n++;
            if (n % 16 == 0) begin
              check($sformatf("frame_%02h_bit%0d", cur.data, n/16 - 1), bit_ok, 1);
              bit_ok = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic wait_ack(input int which, input int budget, output int at_cycle);
    logic found = 1'b0;
    at_cycle = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clock);
      #1;
      if ((which == 0 ? bus.ack0 : bus.ack1) === 1'b1) begin
        found    = 1'b1;
        at_cycle = cycle;
      end
    end
    check($sformatf("ack%0d_seen", which), found, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) begin
      @(negedge clock);
      #1;
    end
    check($sformatf("tx_done_count_%0d", target), 32'(done_cnt >= target), 1);
  endtask

  task automatic do_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    reset_n  = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    ack_cnt0 = 0;
    ack_cnt1 = 0;
    done_cnt = 0;
    reset_n  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c_ack;
  int lows;

  initial begin
    bus.tick = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    #1;
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_tx_done", bus.tx_done, 0);
    check("rst_owner", bus.owner, 0);
    reset_n = 1'b1;

    // 1: single 0xA5 frame from requester 0, tick every 4 clocks.
    @(negedge clock);
    #1;
    sb_q.push_back('{owner: 1'b0, data: 8'hA5});
    bus.din0 = 8'hA5;
    bus.req0 = 1'b1;
    wait_ack(0, 50, c_ack);
    bus.req0 = 1'b0;
    wait_done(1, 2000);
    check("t1_ack0_pulses", ack_cnt0, 1);
    @(negedge clock);
    #1;
    check("t1_busy_after", bus.busy, 0);
    check("t1_owner_after", bus.owner, 0);

    // 2: both requesting from reset; req0 wins, req1 follows back-to-back.
    do_reset();
    sb_q.push_back('{owner: 1'b0, data: 8'h11});
    sb_q.push_back('{owner: 1'b1, data: 8'h22});
    bus.din0 = 8'h11;
    bus.din1 = 8'h22;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_ack(0, 50, c_ack);
    bus.req0 = 1'b0;
    wait_ack(1, 2000, c_ack);
    bus.req1 = 1'b0;
    check("t2_grant_after_done", c_ack - done_cycle, 1);
    wait_done(2, 2000);
    check("t2_ack0_pulses", ack_cnt0, 1);
    check("t2_ack1_pulses", ack_cnt1, 1);

    // 3: both held high, tick stuck: grants alternate 0,1,0,1.
    do_reset();
    tick_stuck = 1'b1;
    sb_q.push_back('{owner: 1'b0, data: 8'h3C});
    sb_q.push_back('{owner: 1'b1, data: 8'hC3});
    sb_q.push_back('{owner: 1'b0, data: 8'h3C});
    sb_q.push_back('{owner: 1'b1, data: 8'hC3});
    bus.din0 = 8'h3C;
    bus.din1 = 8'hC3;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    wait_done(4, 1000);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("t3_ack0_pulses", ack_cnt0, 2);
    check("t3_ack1_pulses", ack_cnt1, 2);
    check("t3_owner_last", bus.owner, 1);

    // 4: tick on the grant edge is not counted: START low for 16 clocks.
    do_reset();
    sb_q.push_back('{owner: 1'b0, data: 8'h4B});
    bus.din0 = 8'h4B;
    bus.req0 = 1'b1;
    wait_ack(0, 20, c_ack);
    bus.req0 = 1'b0;
    lows = 0;
    while (bus.tx === 1'b0 && lows < 40) begin
      lows++;
      @(negedge clock);
      #1;
    end
    check("t4_start_low_clocks", lows, 16);
    wait_done(1, 300);

    // 5: reset in DATA bit 3 of a 0xFF frame, then a clean 0x00 from req1.
    do_reset();
    sb_q.push_back('{owner: 1'b0, data: 8'hFF});
    bus.din0 = 8'hFF;
    bus.req0 = 1'b1;
    wait_ack(0, 20, c_ack);
    bus.req0 = 1'b0;
    repeat (70) @(negedge clock);
    #1;
    check("t5_busy_before_reset", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t5_tx_in_reset", bus.tx, 1);
    check("t5_busy_in_reset", bus.busy, 0);
    check("t5_owner_in_reset", bus.owner, 0);
    repeat (2) @(negedge clock);
    #1;
    check("t5_tx_done_in_reset", bus.tx_done, 0);
    reset_n = 1'b1;
    check("t5_no_tx_done", done_cnt, 0);
    sb_q.push_back('{owner: 1'b1, data: 8'h00});
    bus.din1 = 8'h00;
    bus.req1 = 1'b1;
    wait_ack(1, 20, c_ack);
    bus.req1 = 1'b0;
    wait_done(1, 300);

    // 6: req1 raised during the req0 STOP bit waits for tx_done.
    do_reset();
    tick_stuck = 1'b0;
    sb_q.push_back('{owner: 1'b0, data: 8'h96});
    sb_q.push_back('{owner: 1'b1, data: 8'h00});
    bus.din0 = 8'h96;
    bus.req0 = 1'b1;
    wait_ack(0, 50, c_ack);
    bus.req0 = 1'b0;
    repeat (590) @(negedge clock);
    #1;
    check("t6_still_in_frame", done_cnt, 0);
    bus.din1 = 8'h00;
    bus.req1 = 1'b1;
    wait_done(1, 200);
    check("t6_ack1_withheld", ack_cnt1, 0);
    wait_ack(1, 10, c_ack);
    bus.req1 = 1'b0;
    check("t6_ack1_after_done", c_ack - done_cycle, 1);
    wait_done(2, 2000);

    repeat (4) @(negedge clock);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
